// File: rtl/fetch_predict.sv
// fetch_predict: IF stage of a 5-stage RV32I pipeline.
// Owns the PC, predecodes the fetched word, predicts conditional branches with a
// 2-bit bimodal BHT (jal is always taken), and loads the F/D pipeline register.
//
// Ports:
//   clk_i, rst_n_i                 clock (rising edge), async active-low reset
//   F_pc_o / F_instr_i             instruction memory address / same-cycle word
//   PC_stall_i                     hold PC
//   F_stall_i, F_bubble_i          hold / NOP-load the F/D register
//   E_redirect_i, E_redirect_pc_i  execute-stage refetch request and target
//   E_br_valid_i, E_br_pc_i,
//   E_br_taken_i                   resolved conditional branch, trains the BHT
//   D_pc_o, D_instr_o, D_train_taken_o, D_pred_pc_o, D_valid_o   F/D register
module fetch_predict #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter int unsigned BHT_IDX_W = 6,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic [31:0] F_pc_o,
    input  logic [31:0] F_instr_i,
    input  logic        PC_stall_i,
    input  logic        F_stall_i,
    input  logic        F_bubble_i,
    input  logic        E_redirect_i,
    input  logic [31:0] E_redirect_pc_i,
    input  logic        E_br_valid_i,
    input  logic [31:0] E_br_pc_i,
    input  logic        E_br_taken_i,
    output logic [31:0] D_pc_o,
    output logic [31:0] D_instr_o,
    output logic        D_train_taken_o,
    output logic [31:0] D_pred_pc_o,
    output logic        D_valid_o
);

    localparam int unsigned BhtEntries = 2 ** BHT_IDX_W;
    localparam logic [6:0]  OpBranch   = 7'b1100011;
    localparam logic [6:0]  OpJal      = 7'b1101111;

    logic [31:0] pc_q, pc_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic        d_taken_q, d_taken_d;
    logic [31:0] d_pred_q, d_pred_d;
    logic        d_valid_q, d_valid_d;
    logic [1:0]  bht_q [BhtEntries];

    // ---------------- predecode and prediction ----------------
    logic [31:0]          b_imm, j_imm, imm;
    logic                 pred_taken;
    logic [31:0]          pred_pc;
    logic [BHT_IDX_W-1:0] fetch_idx;

    assign b_imm = {{20{F_instr_i[31]}}, F_instr_i[7], F_instr_i[30:25], F_instr_i[11:8], 1'b0};
    assign j_imm = {{12{F_instr_i[31]}}, F_instr_i[19:12], F_instr_i[20], F_instr_i[30:21], 1'b0};
    assign fetch_idx = pc_q[BHT_IDX_W+1:2];

    always_comb begin
        imm        = 32'd0;
        pred_taken = 1'b0;
        case (F_instr_i[6:0])
            OpBranch: begin
                imm        = b_imm;
                pred_taken = bht_q[fetch_idx][1];
            end
            OpJal: begin
                imm        = j_imm;
                pred_taken = 1'b1;
            end
            // jalr and everything else fall through to pc+4
            default: ;
        endcase
        pred_pc = pred_taken ? (pc_q + imm) : (pc_q + 32'd4);
    end

    // ---------------- next PC ----------------
    always_comb begin
        pc_d = pred_pc;
        if (E_redirect_i) begin
            pc_d = E_redirect_pc_i;
        end else if (PC_stall_i) begin
            pc_d = pc_q;
        end
    end

    // ---------------- F/D register next state ----------------
    always_comb begin
        d_pc_d    = pc_q;
        d_instr_d = F_instr_i;
        d_taken_d = pred_taken;
        d_pred_d  = pred_pc;
        d_valid_d = 1'b1;
        if (E_redirect_i) begin
            // squash the single wrong-path word fetched this cycle
            d_instr_d = NOP_INSTR;
            d_taken_d = 1'b0;
            d_valid_d = 1'b0;
        end else if (F_stall_i) begin
            d_pc_d    = d_pc_q;
            d_instr_d = d_instr_q;
            d_taken_d = d_taken_q;
            d_pred_d  = d_pred_q;
            d_valid_d = d_valid_q;
        end else if (F_bubble_i) begin
            d_instr_d = NOP_INSTR;
            d_taken_d = 1'b0;
            d_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q      <= RESET_PC;
            d_pc_q    <= 32'd0;
            d_instr_q <= NOP_INSTR;
            d_taken_q <= 1'b0;
            d_pred_q  <= 32'd0;
            d_valid_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            d_pc_q    <= d_pc_d;
            d_instr_q <= d_instr_d;
            d_taken_q <= d_taken_d;
            d_pred_q  <= d_pred_d;
            d_valid_q <= d_valid_d;
        end
    end

    // ---------------- BHT training ----------------
    // Prediction reads bht_q combinationally; an update to the same entry lands at
    // the edge, so a same-cycle read sees the old counter (no bypass).
    logic [BHT_IDX_W-1:0] upd_idx;
    logic [1:0]           cnt_old, cnt_new;

    assign upd_idx = E_br_pc_i[BHT_IDX_W+1:2];
    assign cnt_old = bht_q[upd_idx];

    always_comb begin
        cnt_new = cnt_old;
        if (E_br_taken_i) begin
            if (cnt_old != 2'b11) cnt_new = cnt_old + 2'b01;
        end else begin
            if (cnt_old != 2'b00) cnt_new = cnt_old - 2'b01;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < BhtEntries; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (E_br_valid_i) begin
            bht_q[upd_idx] <= cnt_new;
        end
    end

    logic unused_br_pc_bits;
    assign unused_br_pc_bits = ^{E_br_pc_i[31:BHT_IDX_W+2], E_br_pc_i[1:0]};

    assign F_pc_o          = pc_q;
    assign D_pc_o          = d_pc_q;
    assign D_instr_o       = d_instr_q;
    assign D_train_taken_o = d_taken_q;
    assign D_pred_pc_o     = d_pred_q;
    assign D_valid_o       = d_valid_q;

endmodule

// File: tb/tb_fetch_predict.sv
// Scoreboard bench for fetch_predict: the driver pushes expected state tagged with
// the cycle it should appear in; a negedge monitor pops and compares.
module tb_fetch_predict;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BEQ  = 32'h0200_0063;  // beq x0,x0,+32
    localparam logic [31:0] JALM = 32'hFF1F_F06F;  // jal x0,-16

    localparam logic [5:0] M_FPC = 6'd1, M_DPC = 6'd2, M_DI = 6'd4;
    localparam logic [5:0] M_DT = 6'd8, M_DP = 6'd16, M_DV = 6'd32, M_ALL = 6'd63;
    localparam logic [5:0] M_SQ = M_FPC | M_DI | M_DT | M_DV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] f_pc, f_instr;
    logic        pc_stall, f_stall, f_bubble;
    logic        e_redirect, e_br_valid, e_br_taken;
    logic [31:0] e_redirect_pc, e_br_pc;
    logic [31:0] d_pc, d_instr, d_pred;
    logic        d_taken, d_valid;

    logic [31:0] imem [256];
    assign f_instr = imem[f_pc[9:2]];

    always #5 clk = ~clk;

    fetch_predict dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .F_pc_o          (f_pc),
        .F_instr_i       (f_instr),
        .PC_stall_i      (pc_stall),
        .F_stall_i       (f_stall),
        .F_bubble_i      (f_bubble),
        .E_redirect_i    (e_redirect),
        .E_redirect_pc_i (e_redirect_pc),
        .E_br_valid_i    (e_br_valid),
        .E_br_pc_i       (e_br_pc),
        .E_br_taken_i    (e_br_taken),
        .D_pc_o          (d_pc),
        .D_instr_o       (d_instr),
        .D_train_taken_o (d_taken),
        .D_pred_pc_o     (d_pred),
        .D_valid_o       (d_valid)
    );

    typedef struct {
        int          when;
        string       name;
        logic [5:0]  m;
        logic [31:0] fpc, dpc, dinstr, dpred;
        logic        dtaken, dvalid;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int when, input string name, input logic [5:0] m,
                        input logic [31:0] fpc, input logic [31:0] dpc,
                        input logic [31:0] dinstr, input logic dtaken,
                        input logic [31:0] dpred, input logic dvalid);
        exp_t e;
        e.when = when; e.name = name; e.m = m; e.fpc = fpc; e.dpc = dpc;
        e.dinstr = dinstr; e.dtaken = dtaken; e.dpred = dpred; e.dvalid = dvalid;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h (cycle %0d)", nm, fld, act, exp, cyc);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].when <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.when < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s.stale: got cycle %0d expected cycle %0d", e.name, cyc, e.when);
            end else begin
                if (e.m[0]) chk(e.name, "F_pc", f_pc, e.fpc);
                if (e.m[1]) chk(e.name, "D_pc", d_pc, e.dpc);
                if (e.m[2]) chk(e.name, "D_instr", d_instr, e.dinstr);
                if (e.m[3]) chk(e.name, "D_taken", {31'd0, d_taken}, {31'd0, e.dtaken});
                if (e.m[4]) chk(e.name, "D_pred", d_pred, e.dpred);
                if (e.m[5]) chk(e.name, "D_valid", {31'd0, d_valid}, {31'd0, e.dvalid});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // saturation table: BHT inputs applied before an edge, predicted-taken after it
    typedef struct { logic v; logic t; logic exp; } sat_t;
    sat_t sat [16] = '{
        '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b1}, '{1'b1, 1'b1, 1'b1}, '{1'b1, 1'b1, 1'b1},
        '{1'b1, 1'b1, 1'b1}, '{1'b1, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b1}, '{1'b1, 1'b0, 1'b1},
        '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0},
        '{1'b1, 1'b1, 1'b0}, '{1'b0, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b0}, '{1'b0, 1'b0, 1'b1}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = NOP;
        imem[8'h04] = BEQ;   // 0x8000_0010
        imem[8'h08] = JALM;  // 0x8000_0020
        imem[8'h10] = BEQ;   // 0x8000_0040
        rst_n = 1'b0;
        pc_stall = 0; f_stall = 0; f_bubble = 0;
        e_redirect = 0; e_redirect_pc = 0; e_br_valid = 0; e_br_pc = 0; e_br_taken = 0;

        repeat (3) @(posedge clk);
        #1;
        push(cyc, "reset", M_ALL, 32'h8000_0000, 32'd0, NOP, 1'b0, 32'd0, 1'b0);
        rst_n = 1'b1;
        step(); step();
        push(cyc + 1, "seq3", M_ALL, 32'h8000_000C, 32'h8000_0008, NOP, 1'b0,
             32'h8000_000C, 1'b1);
        step();
        step();  // F at branch 0x10
        push(cyc + 1, "br_nt", M_ALL, 32'h8000_0014, 32'h8000_0010, BEQ, 1'b0,
             32'h8000_0014, 1'b1);
        step();

        // train taken twice, then refetch the branch
        e_br_valid = 1; e_br_pc = 32'h8000_0010; e_br_taken = 1;
        step();
        e_redirect = 1; e_redirect_pc = 32'h8000_0010;
        push(cyc + 1, "redir_br", M_SQ, 32'h8000_0010, 0, NOP, 1'b0, 0, 1'b0);
        step();
        e_br_valid = 0; e_redirect = 0;
        push(cyc + 1, "br_tk", M_ALL, 32'h8000_0030, 32'h8000_0010, BEQ, 1'b1,
             32'h8000_0030, 1'b1);
        step();

        // jal with negative offset
        e_redirect = 1; e_redirect_pc = 32'h8000_0020;
        push(cyc + 1, "redir_jal", M_SQ, 32'h8000_0020, 0, NOP, 1'b0, 0, 1'b0);
        step();
        e_redirect = 0;
        push(cyc + 1, "jal", M_ALL, 32'h8000_0010, 32'h8000_0020, JALM, 1'b1,
             32'h8000_0010, 1'b1);
        step();

        // stall wins over bubble
        pc_stall = 1; f_stall = 1; f_bubble = 1;
        push(cyc + 1, "stall1", M_ALL, 32'h8000_0010, 32'h8000_0020, JALM, 1'b1,
             32'h8000_0010, 1'b1);
        step();
        push(cyc + 1, "stall2", M_ALL, 32'h8000_0010, 32'h8000_0020, JALM, 1'b1,
             32'h8000_0010, 1'b1);
        step();
        pc_stall = 0; f_stall = 0;
        push(cyc + 1, "bubble", M_SQ | M_DPC, 32'h8000_0030, 32'h8000_0010, NOP, 1'b0,
             0, 1'b0);
        step();
        f_bubble = 0;
        push(cyc + 1, "post_bub", M_ALL, 32'h8000_0034, 32'h8000_0030, NOP, 1'b0,
             32'h8000_0034, 1'b1);
        step();

        // redirect overrides PC stall
        e_redirect = 1; e_redirect_pc = 32'h8000_0100; pc_stall = 1;
        push(cyc + 1, "redir_stall", M_SQ, 32'h8000_0100, 0, NOP, 1'b0, 0, 1'b0);
        step();
        e_redirect_pc = 32'h8000_0040; pc_stall = 0;
        push(cyc + 1, "redir_40", M_SQ, 32'h8000_0040, 0, NOP, 1'b0, 0, 1'b0);
        step();
        e_redirect = 0;

        // saturation: refetch the branch at 0x40 every cycle while training it
        pc_stall = 1;
        e_br_pc = 32'h8000_0040;
        for (int i = 0; i < 16; i++) begin
            e_br_valid = sat[i].v;
            e_br_taken = sat[i].t;
            push(cyc + 1, $sformatf("sat%0d", i), M_ALL, 32'h8000_0040, 32'h8000_0040, BEQ,
                 sat[i].exp, sat[i].exp ? 32'h8000_0060 : 32'h8000_0044, 1'b1);
            step();
        end
        e_br_valid = 0; pc_stall = 0;

        repeat (3) step();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
